// File: rtl/hpdsm_modulator.sv
// High-pass (Nyquist-band) delta-sigma modulator: ORDER cascaded z=-1 resonators,
// 1-bit quantizer, +/-H feedback and guard-bit saturation, strobed by in_valid.
module hpdsm_modulator #(
  parameter int WIDTH = 16,
  parameter int ORDER = 2,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] xi,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);

  localparam int SW = WIDTH + GUARD;
  localparam int EW = SW + 2;
  localparam logic signed [EW-1:0] H_E = {{(EW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};

  if (ORDER != 32'sd1 && ORDER != 32'sd2) begin : gen_order_check
    $error("hpdsm_modulator: ORDER must be 1 or 2");
  end

  // Clamp an EW-bit value to SW bits; MSB of the result flags that clamping happened.
  function automatic logic [SW:0] sat(input logic signed [EW-1:0] v);
    logic [SW:0] r;
    if (v[EW-1:SW-1] == 3'b000 || v[EW-1:SW-1] == 3'b111) begin
      r = {1'b0, v[SW-1:0]};
    end else if (v[EW-1]) begin
      r = {1'b1, 1'b1, {(SW-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(SW-1){1'b1}}};
    end
    return r;
  endfunction

  logic [SW-1:0] t1;
  logic [SW-1:0] t2;
  logic signed [EW-1:0] xe, xh, fb, t1_e, t2_e, d1, d2, sum1, sum2;
  logic [SW:0] s1, s2;
  logic q;
  logic sat_any;

  // Loop arithmetic: quantize the pre-update state, then form the saturated next states.
  always_comb begin
    q    = (ORDER == 32'sd1) ? t1[SW-1] : t2[SW-1];
    xe   = {{(EW-WIDTH){xi[WIDTH-1]}}, xi};
    xh   = xe >>> 1;
    fb   = q ? H_E : -H_E;
    t1_e = {{2{t1[SW-1]}}, t1};
    t2_e = {{2{t2[SW-1]}}, t2};
    d1   = xh - fb;
    d2   = t1_e - fb;
    if (ORDER == 32'sd1) begin
      sum1 = d1 - t1_e;
      sum2 = {EW{1'b0}};
    end else begin
      sum1 = (d1 >>> 1) - t1_e;
      sum2 = (d2 >>> 1) - t2_e;
    end
    s1      = sat(sum1);
    s2      = sat(sum2);
    sat_any = s1[SW] | s2[SW];
  end

  // Loop state and output bit; clear drops a coincident sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1        <= {SW{1'b0}};
      t2        <= {SW{1'b0}};
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      t1        <= {SW{1'b0}};
      t2        <= {SW{1'b0}};
      out_valid <= 1'b0;
    end else if (in_valid) begin
      t1        <= s1[SW-1:0];
      t2        <= s2[SW-1:0];
      out_bit   <= q;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new saturation wins over ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (in_valid && !clear && sat_any) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_sticky;
    end
  end

endmodule

// File: tb/tb_hpdsm_modulator.sv
// Bench for hpdsm_modulator: three instances (ORDER1/G4, ORDER2/G4, ORDER2/G0) on shared
// stimulus, checked against an integer model through a scoreboard queue.
module tb_hpdsm_modulator;

  logic clk;
  logic rst, clear, in_valid, ovf_clr;
  logic [15:0] xi;
  logic [2:0] ov, ob, os;

  int errors = 0;
  int checks = 0;

  hpdsm_modulator #(.WIDTH(16), .ORDER(1), .GUARD(4)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xi(xi),
    .out_valid(ov[0]), .out_bit(ob[0]), .ovf_clr(ovf_clr), .ovf_sticky(os[0]));
  hpdsm_modulator #(.WIDTH(16), .ORDER(2), .GUARD(4)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xi(xi),
    .out_valid(ov[1]), .out_bit(ob[1]), .ovf_clr(ovf_clr), .ovf_sticky(os[1]));
  hpdsm_modulator #(.WIDTH(16), .ORDER(2), .GUARD(0)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .xi(xi),
    .out_valid(ov[2]), .out_bit(ob[2]), .ovf_clr(ovf_clr), .ovf_sticky(os[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state per instance
  longint mt1 [3];
  longint mt2 [3];
  bit     movf [3];
  bit     msat [3];

  logic [2:0] sbq [$];
  logic       exp_valid = 1'b0;
  logic       exp_rst = 1'b0;
  logic [2:0] exp_ovf = 3'b000;
  logic [2:0] held = 3'b000;
  bit         mon_en = 1'b0;

  function automatic int ord_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int sw_of(input int k);
    return (k == 2) ? 16 : 20;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic v, input logic [15:0] x,
                            input logic oc, output logic [2:0] qv);
    for (int k = 0; k < 3; k++) begin
      longint h, fb, xh, n1, n2, mx, mn;
      bit q, s;
      s = 1'b0;
      q = ((ord_of(k) == 1) ? mt1[k] : mt2[k]) < 0;
      qv[k] = q;
      if (r) begin
        mt1[k] = 0; mt2[k] = 0; movf[k] = 1'b0;
      end else begin
        if (!c && v) begin
          h  = 16384;
          fb = q ? h : -h;
          xh = longint'($signed(x)) >>> 1;
          if (ord_of(k) == 1) begin
            n1 = xh - fb - mt1[k];
            n2 = 0;
          end else begin
            n1 = ((xh - fb) >>> 1) - mt1[k];
            n2 = ((mt1[k] - fb) >>> 1) - mt2[k];
          end
          mx = (64'sd1 <<< (sw_of(k) - 1)) - 1;
          mn = -mx - 1;
          if (n1 > mx) begin n1 = mx; s = 1'b1; end
          else if (n1 < mn) begin n1 = mn; s = 1'b1; end
          if (n2 > mx) begin n2 = mx; s = 1'b1; end
          else if (n2 < mn) begin n2 = mn; s = 1'b1; end
          mt1[k] = n1;
          mt2[k] = n2;
        end
        if (c) begin
          mt1[k] = 0; mt2[k] = 0;
        end
        if (s) movf[k] = 1'b1;
        else if (oc) movf[k] = 1'b0;
      end
      msat[k] = s;
    end
  endtask

  // Drive one cycle of stimulus, predict, then leave time just past the edge.
  task automatic step_cycle(input logic r, input logic c, input logic v, input logic [15:0] x,
                            input logic oc);
    logic [2:0] qv;
    rst = r; clear = c; in_valid = v; xi = x; ovf_clr = oc;
    model_step(r, c, v, x, oc, qv);
    if (!r && !c && v) sbq.push_back(qv);
    @(posedge clk);
    exp_rst   = r;
    exp_valid = !r && !c && v;
    exp_ovf   = {movf[2], movf[1], movf[0]};
    #2;
  endtask

  // Scoreboard monitor on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_rst) held = 3'b000;
      checks++;
      if (ov !== {3{exp_valid}}) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", ov, {3{exp_valid}});
      end
      if (exp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: got out_valid, want a queued expectation (queue empty)");
        end else begin
          held = sbq.pop_front();
        end
      end
      checks++;
      if (ob !== held) begin
        errors++;
        $display("FAIL out_bit: got %b want %b", ob, held);
      end
      checks++;
      if (os !== exp_ovf) begin
        errors++;
        $display("FAIL ovf_sticky: got %b want %b", os, exp_ovf);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step_cycle(1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      mon_en = 1'b1;
      checks++;
      if (ov !== 3'b000 || ob !== 3'b000 || os !== 3'b000) begin
        errors++;
        $display("FAIL reset: got valid=%b bit=%b ovf=%b want 000/000/000", ov, ob, os);
      end
    end
  endtask

  task automatic test_dc_zero();
    for (int i = 0; i < 8; i++) begin
      step_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      checks++;
      if (ov[0] !== 1'b1 || ob[0] !== 1'b0) begin
        errors++;
        $display("FAIL dc_zero[%0d]: got valid=%b bit=%b want 1/0", i, ov[0], ob[0]);
      end
    end
  endtask

  task automatic test_strobe();
    step_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step_cycle(1'b0, 1'b0, (i % 3 == 0), 16'h0000, 1'b0);
      checks++;
      if (ov[0] !== (i % 3 == 0)) begin
        errors++;
        $display("FAIL strobe[%0d]: got valid=%b want %b", i, ov[0], (i % 3 == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int dev;
    acc = 0;
    step_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int n = 0; n < 4096; n++) begin
      step_cycle(1'b0, 1'b0, 1'b1, (n % 2 == 0) ? 16'h2000 : 16'hE000, 1'b0);
      acc += ((n % 2 == 0) ? 1 : -1) * (ob[0] ? 1 : -1);
    end
    dev = acc - 1024;
    checks++;
    if (dev > 82 || dev < -82) begin
      errors++;
      $display("FAIL demod_mean: got sum=%0d want 1024 +/- 82", acc);
    end
    checks++;
    if (os[0] !== 1'b0) begin
      errors++;
      $display("FAIL order1_no_ovf: got %b want 0", os[0]);
    end
  endtask

  task automatic test_saturation();
    bit found;
    found = 1'b0;
    step_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int n = 0; n < 64; n++)
      step_cycle(1'b0, 1'b0, 1'b1, (n % 2 == 0) ? 16'h7FFF : 16'h8001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (os[2] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_held[%0d]: got %b want 1", i, os[2]);
      end
    end
    step_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (os[2] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", os[2]);
    end
    for (int n = 0; n < 64 && !found; n++) begin
      step_cycle(1'b0, 1'b0, 1'b1, (n % 2 == 0) ? 16'h7FFF : 16'h8001, 1'b1);
      if (msat[2]) begin
        found = 1'b1;
        checks++;
        if (os[2] !== 1'b1) begin
          errors++;
          $display("FAIL ovf_clr_vs_sat: got %b want 1", os[2]);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ovf_clr_vs_sat: got no saturating step want one within 64 samples");
    end
  endtask

  task automatic test_clear_midstream();
    step_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int n = 0; n < 10; n++)
      step_cycle(1'b0, 1'b0, 1'b1, (n % 2 == 0) ? 16'h5000 : 16'hB000, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b1, 16'h5000, 1'b0);
    checks++;
    if (ov !== 3'b000) begin
      errors++;
      $display("FAIL clear_drop: got valid=%b want 000", ov);
    end
    step_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (ov !== 3'b111 || ob !== 3'b000) begin
      errors++;
      $display("FAIL clear_first: got valid=%b bit=%b want 111/000", ov, ob);
    end
    for (int n = 0; n < 64; n++)
      step_cycle(1'b0, 1'b0, 1'b1, (n % 2 == 0) ? 16'h7FFF : 16'h8001, 1'b0);
    checks++;
    if (os[2] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_ovf: got %b want 1", os[2]);
    end
    step_cycle(1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b0);
    checks++;
    if (ov !== 3'b000 || os !== 3'b000 || ob !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: got valid=%b ovf=%b bit=%b want 000/000/000", ov, os, ob);
    end
    step_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (ov !== 3'b111 || ob !== 3'b000) begin
      errors++;
      $display("FAIL rst_first: got valid=%b bit=%b want 111/000", ov, ob);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; xi = 16'h0000; ovf_clr = 1'b0;
    test_reset();
    test_dc_zero();
    test_strobe();
    test_back_to_back();
    test_saturation();
    test_clear_midstream();
    step_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
